// File: rtl/key_cursor_ctrl.sv
// Keypad cursor controller: debounces five active-low buttons, walks a COLS x ROWS
// cursor with wrap-around and hold-to-repeat, and strobes the selected key code on ok.
module key_cursor_ctrl #(
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned COLS          = 3,
  parameter int unsigned ROWS          = 4
) (
  input  logic       clk_in,
  input  logic       sys_rst_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_ok_n,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic [7:0] key_code,
  output logic       key_valid
);

  localparam int unsigned DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW    = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int unsigned K_OK  = 4;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, HOLD, REPT} rep_state_t;

  logic [4:0]          raw_n;
  logic [4:0]          sync1, sync2;
  logic [4:0]          pressed;
  logic [4:0]          deb;
  logic [4:0][DW-1:0]  deb_cnt;
  logic [4:0]          press_ev;

  rep_state_t          state;
  dir_t                lat_dir;
  logic [RW-1:0]       rcnt;

  logic                press_any;
  dir_t                press_dir;
  logic                lat_held;
  logic                rep_step;
  logic                move_en;
  dir_t                move_dir;
  logic [7:0]          sel_code;

  assign raw_n   = {key_ok_n, key_right_n, key_left_n, key_down_n, key_up_n};
  assign pressed = ~sync2;

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1    <= '1;
      sync2    <= '1;
      deb      <= '0;
      deb_cnt  <= '0;
      press_ev <= '0;
    end else begin
      sync1    <= raw_n;
      sync2    <= sync1;
      press_ev <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        if (pressed[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]      <= ~deb[i];
          deb_cnt[i]  <= '0;
          press_ev[i] <= ~deb[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fixed priority up > down > left > right; losers in the same cycle are dropped.
  always_comb begin
    press_any = |press_ev[3:0];
    press_dir = DIR_RIGHT;
    if (press_ev[0])      press_dir = DIR_UP;
    else if (press_ev[1]) press_dir = DIR_DOWN;
    else if (press_ev[2]) press_dir = DIR_LEFT;
    lat_held = deb[lat_dir];
    rep_step = lat_held &&
               (((state == HOLD) && (rcnt == RW'(REPEAT_DELAY - 1))) ||
                ((state == REPT) && (rcnt == RW'(REPEAT_PERIOD - 1))));
    move_en  = press_any || rep_step;
    move_dir = press_any ? press_dir : lat_dir;
  end

  always_comb begin
    sel_code = 8'h00;
    case ({cursor_y, cursor_x})
      8'h00: sel_code = 8'h31;
      8'h01: sel_code = 8'h32;
      8'h02: sel_code = 8'h33;
      8'h10: sel_code = 8'h34;
      8'h11: sel_code = 8'h35;
      8'h12: sel_code = 8'h36;
      8'h20: sel_code = 8'h37;
      8'h21: sel_code = 8'h38;
      8'h22: sel_code = 8'h39;
      8'h30: sel_code = 8'h2B;
      8'h31: sel_code = 8'h30;
      8'h32: sel_code = 8'h3D;
      default: sel_code = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cursor_x  <= '0;
      cursor_y  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      state     <= IDLE;
      lat_dir   <= DIR_UP;
      rcnt      <= '0;
    end else begin
      key_valid <= press_ev[K_OK];
      if (press_ev[K_OK]) key_code <= sel_code;

      if (move_en) begin
        case (move_dir)
          DIR_UP:    cursor_y <= (cursor_y == '0) ? 4'(ROWS - 1) : cursor_y - 1'b1;
          DIR_DOWN:  cursor_y <= (cursor_y == 4'(ROWS - 1)) ? '0 : cursor_y + 1'b1;
          DIR_LEFT:  cursor_x <= (cursor_x == '0) ? 4'(COLS - 1) : cursor_x - 1'b1;
          default:   cursor_x <= (cursor_x == 4'(COLS - 1)) ? '0 : cursor_x + 1'b1;
        endcase
      end

      // A fresh press always restarts the hold timer; release beats a due step.
      if (press_any) begin
        lat_dir <= press_dir;
        rcnt    <= '0;
        state   <= HOLD;
      end else begin
        case (state)
          HOLD, REPT: begin
            if (!lat_held) begin
              state <= IDLE;
              rcnt  <= '0;
            end else if (rep_step) begin
              state <= REPT;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
